// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {bo,d} = a - b - bi, LSB first, one bit per clock.
// Streaming valid/ready ports on both sides; one operation in flight at a time.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bi_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] d_o,
  output logic             bo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic             vld_q, vld_d;

  logic             dbit;
  logic             br_nx;
  logic [WIDTH:0]   r_sh;

  assign dbit  = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_nx = (~sa_q[0] & sb_q[0])
               | (~(sa_q[0] ^ sb_q[0]) & br_q);
  assign r_sh  = {dbit, r_q};

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = vld_q;
  assign d_o         = d_q;
  assign bo_o        = bo_q;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          sa_d    = a_i;
          sb_d    = b_i;
          br_d    = bi_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        r_d   = r_sh[WIDTH:1];
        br_d  = br_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // First DONE cycle registers the result, then it is presented
        if (!vld_q) begin
          vld_d = 1'b1;
          d_d   = r_q;
          bo_d  = br_q;
        end else if (out_ready_i) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH 8, 1 and 16.
// Expected values are hand-computed or from an a-b-bi golden model.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  logic       iv8, ir8, bi8, ov8, or8, bo8;
  logic [7:0] a8, b8, d8;

  logic       iv1, ir1, bi1, ov1, or1, bo1;
  logic [0:0] a1, b1, d1;

  logic        iv16, ir16, bi16, ov16, or16, bo16;
  logic [15:0] a16, b16, d16;

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(iv8), .in_ready_o(ir8),
    .a_i(a8), .b_i(b8), .bi_i(bi8),
    .out_valid_o(ov8), .out_ready_i(or8),
    .d_o(d8), .bo_o(bo8)
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(iv1), .in_ready_o(ir1),
    .a_i(a1), .b_i(b1), .bi_i(bi1),
    .out_valid_o(ov1), .out_ready_i(or1),
    .d_o(d1), .bo_o(bo1)
  );

  serial_subtractor #(.WIDTH(16)) u16 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(iv16), .in_ready_o(ir16),
    .a_i(a16), .b_i(b16), .bi_i(bi16),
    .out_valid_o(ov16), .out_ready_i(or16),
    .d_o(d16), .bo_o(bo16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs,
                     input logic [31:0] exp,
                     input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept, wait for result, check latency/result, then handshake
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic bi, input logic [7:0] ed,
                     input logic eb, input string tag);
    int n;
    chk(32'(ir8), 32'd1, {tag, "_ready"});
    a8 = a; b8 = b; bi8 = bi; iv8 = 1'b1; or8 = 1'b1;
    tick();
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 50) begin
      tick();
      n++;
    end
    chk(32'(n), 32'd9, {tag, "_lat"});
    chk(32'(d8), 32'(ed), {tag, "_d"});
    chk(32'(bo8), 32'(eb), {tag, "_bo"});
    tick();
    chk(32'(ov8), 32'd0, {tag, "_vld_drop"});
    chk(32'(ir8), 32'd1, {tag, "_ready_back"});
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      input logic bi);
    int n;
    logic [16:0] g;
    g = {1'b0, a} - {1'b0, b} - {16'd0, bi};
    a16 = a; b16 = b; bi16 = bi; iv16 = 1'b1; or16 = 1'b1;
    tick();
    iv16 = 1'b0;
    n = 0;
    while (!ov16 && n < 50) begin
      tick();
      n++;
    end
    chk(32'(n), 32'd17, "w16_lat");
    chk(32'(d16), 32'(g[15:0]), "w16_d");
    chk(32'(bo16), 32'(g[16]), "w16_bo");
    tick();
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    iv8 = 0; a8 = '0; b8 = '0; bi8 = 0; or8 = 0;
    iv1 = 0; a1 = '0; b1 = '0; bi1 = 0; or1 = 0;
    iv16 = 0; a16 = '0; b16 = '0; bi16 = 0; or16 = 0;
    #3;
    chk(32'(ir8), 32'd1, "rst_ready");
    chk(32'(ov8), 32'd0, "rst_valid");
    chk(32'(d8), 32'd0, "rst_d");
    chk(32'(bo8), 32'd0, "rst_bo");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    op8(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, "t1");
    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "t2a");
    op8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, "t2b");
    op8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, "t3a");
    op8(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, "t3b");

    // Backpressure with a second operand pending
    a8 = 8'h5A; b8 = 8'h23; bi8 = 1'b0; iv8 = 1'b1; or8 = 1'b0;
    tick();
    a8 = 8'h11;
    n = 0;
    while (!ov8 && n < 50) begin
      tick();
      n++;
    end
    chk(32'(n), 32'd9, "t4_lat");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk(32'(ov8), 32'd1, "t4_hold_vld");
      chk(32'(d8), 32'h37, "t4_hold_d");
      chk(32'(bo8), 32'd0, "t4_hold_bo");
      chk(32'(ir8), 32'd0, "t4_hold_ready");
    end
    or8 = 1'b1;
    tick();
    chk(32'(ir8), 32'd1, "t4_ready_back");
    tick();
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 50) begin
      tick();
      n++;
    end
    chk(32'(n), 32'd9, "t4b_lat");
    chk(32'(d8), 32'hEE, "t4b_d");
    chk(32'(bo8), 32'd1, "t4b_bo");
    tick();

    // Asynchronous reset three cycles into RUN
    a8 = 8'h5A; b8 = 8'h23; bi8 = 1'b0; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk(32'(ov8), 32'd0, "t5_rst_vld");
    chk(32'(d8), 32'd0, "t5_rst_d");
    chk(32'(ir8), 32'd1, "t5_rst_ready");
    #1 rst_n = 1'b1;
    tick();
    op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "t5b");

    // WIDTH=1
    a1 = 1'b0; b1 = 1'b1; bi1 = 1'b1; iv1 = 1'b1; or1 = 1'b1;
    tick();
    iv1 = 1'b0;
    n = 0;
    while (!ov1 && n < 50) begin
      tick();
      n++;
    end
    chk(32'(n), 32'd2, "w1_lat");
    chk(32'(d1), 32'd0, "w1_d");
    chk(32'(bo1), 32'd1, "w1_bo");
    tick();
    chk(32'(ir1), 32'd1, "w1_ready_back");

    // WIDTH=16 corners then random sweep
    op16(16'h0000, 16'hFFFF, 1'b1);
    op16(16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
